mem_lsu: RTL and testbench



---
 rtl/mem_lsu_if.sv | 22 ++
 rtl/mem_lsu.sv | 90 +++++++++
 tb/tb_mem_lsu.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: data-bus bundle between the load/store unit (master) and memory (slave).
// Signals: data_req/data_wr/data_size/data_addr/data_wstrb/data_wdata from master,
//          data_addr_ok/data_data_ok/data_rdata from slave.
interface mem_lsu_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit issuing one req/addr_ok/data_ok transaction per access.
// Ports: clk, rst (async active-high); MEM_* instruction fields from the EXE/MEM register;
//        bus (mem_lsu_if.master) data bus; MEM_LoadData, MEM_AdEL, MEM_AdES, MEM_BadVAddr,
//        MEM_Stall back to the pipeline.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_Valid,
  input  logic        MEM_ExcptIn,
  input  logic        MEM_Flush,
  input  logic        MEM_Advance,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_OutB,
  input  logic        MEM_LoadEn,
  input  logic        MEM_StoreEn,
  input  logic [1:0]  MEM_Size,
  input  logic        MEM_LoadSign,
  mem_lsu_if.master   bus,
  output logic [31:0] MEM_LoadData,
  output logic        MEM_AdEL,
  output logic        MEM_AdES,
  output logic [31:0] MEM_BadVAddr,
  output logic        MEM_Stall
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_word, is_half, misalign, chk, access, req, stall;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  // Size 3 is illegal and behaves as a word access.
  assign is_word  = MEM_Size[1];
  assign is_half  = MEM_Size == 2'd1;
  assign misalign = (is_half & MEM_ALUOut[0]) | (is_word & |MEM_ALUOut[1:0]);
  assign chk      = MEM_Valid & ~MEM_ExcptIn;
  assign access   = chk & (MEM_LoadEn | MEM_StoreEn) & ~misalign & ~MEM_Flush;
  assign MEM_AdEL     = chk & MEM_LoadEn & misalign;
  assign MEM_AdES     = chk & MEM_StoreEn & misalign;
  assign MEM_BadVAddr = MEM_ALUOut;
  // Request fields come straight from the MEM register, which the stall holds steady until addr_ok.
  assign bus.data_wr    = MEM_StoreEn;
  assign bus.data_size  = MEM_Size;
  assign bus.data_addr  = MEM_ALUOut;
  assign bus.data_wstrb = is_word ? 4'b1111 : (is_half ? 4'b0011 : 4'b0001) << MEM_ALUOut[1:0];
  assign bus.data_wdata = is_word ? MEM_OutB : is_half ? {2{MEM_OutB[15:0]}} : {4{MEM_OutB[7:0]}};
  assign ld_b = rdata_q[{MEM_ALUOut[1:0], 3'b000} +: 8];
  assign ld_h = rdata_q[{MEM_ALUOut[1], 4'b0000} +: 16];
  assign MEM_LoadData = is_word ? rdata_q :
                        is_half ? {{16{MEM_LoadSign & ld_h[15]}}, ld_h} :
                                  {{24{MEM_LoadSign & ld_b[7]}}, ld_b};
  // Reset gates the bus request and stall combinationally so they are low for the whole reset.
  assign bus.data_req = req & ~rst;
  assign MEM_Stall    = stall & ~rst;
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    req     = 1'b0;
    stall   = 1'b1;
    case (state_q)
      IDLE: begin
        req     = access;
        stall   = access;
        state_d = ~access ? IDLE : bus.data_addr_ok ? WAIT : REQ;
      end
      REQ: begin
        req     = 1'b1;
        state_d = MEM_Flush ? (bus.data_addr_ok ? DRAIN : IDLE) : (bus.data_addr_ok ? WAIT : REQ);
      end
      WAIT: begin
        state_d = bus.data_data_ok ? (MEM_Flush ? IDLE : DONE) : (MEM_Flush ? DRAIN : WAIT);
        rdata_d = bus.data_data_ok & ~MEM_Flush ? bus.data_rdata : rdata_q;
      end
      DONE: begin
        stall   = 1'b0;
        state_d = MEM_Flush | MEM_Advance ? IDLE : DONE;
      end
      DRAIN: state_d = bus.data_data_ok ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and randomized cycle-scripted checks of mem_lsu against a behavioural model.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_Valid, MEM_ExcptIn, MEM_Flush, MEM_Advance, MEM_LoadEn, MEM_StoreEn, MEM_LoadSign;
  logic [31:0] MEM_ALUOut, MEM_OutB, MEM_LoadData, MEM_BadVAddr;
  logic [1:0]  MEM_Size;
  logic        MEM_AdEL, MEM_AdES, MEM_Stall;
  int          n_checks = 0;
  int          n_fail = 0;
  mem_lsu_if bus();
  mem_lsu dut (
    .clk(clk), .rst(rst), .MEM_Valid(MEM_Valid), .MEM_ExcptIn(MEM_ExcptIn), .MEM_Flush(MEM_Flush),
    .MEM_Advance(MEM_Advance), .MEM_ALUOut(MEM_ALUOut), .MEM_OutB(MEM_OutB),
    .MEM_LoadEn(MEM_LoadEn), .MEM_StoreEn(MEM_StoreEn), .MEM_Size(MEM_Size),
    .MEM_LoadSign(MEM_LoadSign), .bus(bus), .MEM_LoadData(MEM_LoadData), .MEM_AdEL(MEM_AdEL),
    .MEM_AdES(MEM_AdES), .MEM_BadVAddr(MEM_BadVAddr), .MEM_Stall(MEM_Stall)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic mis(input logic [1:0] sz, input logic [31:0] a);
    return sz == 2'd1 ? a[0] : sz >= 2'd2 ? (a % 4 != 0) : 1'b0;
  endfunction
  function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [31:0] a);
    int lane = a % 4;
    return sz == 2'd0 ? 4'(1 << lane) : sz == 2'd1 ? 4'(3 << lane) : 4'hf;
  endfunction
  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] b);
    return sz == 2'd0 ? (b % 256) * 32'h01010101 : sz == 2'd1 ? (b % 65536) * 32'h00010001 : b;
  endfunction
  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (sz >= 2'd2) return rd;
    if (sz == 2'd1) begin
      v = (rd >> (16 * ((a / 2) % 2))) % 65536;
      return (sg && v >= 32768) ? v - 65536 : v;
    end
    v = (rd >> (8 * (a % 4))) % 256;
    return (sg && v >= 128) ? v - 256 : v;
  endfunction
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic set_instr(input logic [31:0] a, input logic [31:0] b, input logic ld, input logic st,
                           input logic [1:0] sz, input logic sg, input logic ex);
    MEM_Valid = 1'b1; MEM_ExcptIn = ex; MEM_Flush = 1'b0; MEM_ALUOut = a; MEM_OutB = b;
    MEM_LoadEn = ld; MEM_StoreEn = st; MEM_Size = sz; MEM_LoadSign = sg;
  endtask
  task automatic run_instr(input logic [31:0] a, input logic [31:0] b, input logic ld, input logic st,
                           input logic [1:0] sz, input logic sg, input logic ex,
                           input int a_dly, input int d_dly, input int hold, input logic [31:0] rd);
    logic m = mis(sz, a);
    set_instr(a, b, ld, st, sz, sg, ex);
    if (!(ld | st) || ex || m) begin
      MEM_Advance = 1'b1; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
      @(negedge clk);
      check("pass_req", bus.data_req, 0);
      check("pass_stall", MEM_Stall, 0);
      check("adel", MEM_AdEL, ld & ~ex & m);
      check("ades", MEM_AdES, st & ~ex & m);
      if (m) check("badvaddr", MEM_BadVAddr, a);
      next_cycle();
      return;
    end
    MEM_Advance = 1'b0;
    for (int t = 0; t <= a_dly; t++) begin
      bus.data_addr_ok = (t == a_dly); bus.data_data_ok = 1'b0;
      @(negedge clk);
      check("req", bus.data_req, 1);
      check("req_stall", MEM_Stall, 1);
      check("wr", bus.data_wr, st);
      check("addr", bus.data_addr, a);
      check("size", bus.data_size, sz);
      if (st) check("wstrb", bus.data_wstrb, exp_strb(sz, a));
      if (st) check("wdata", bus.data_wdata, exp_wdata(sz, b));
      next_cycle();
    end
    for (int t = 0; t <= d_dly; t++) begin
      bus.data_addr_ok = 1'b0; bus.data_data_ok = (t == d_dly);
      bus.data_rdata = (t == d_dly) ? rd : $urandom;
      @(negedge clk);
      check("wait_req", bus.data_req, 0);
      check("wait_stall", MEM_Stall, 1);
      next_cycle();
    end
    bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
    for (int t = 0; t <= hold; t++) begin
      MEM_Advance = (t == hold);
      @(negedge clk);
      check("done_stall", MEM_Stall, 0);
      check("done_req", bus.data_req, 0);
      if (ld) check("loaddata", MEM_LoadData, exp_load(sz, sg, a, rd));
      next_cycle();
    end
  endtask
  task automatic bus_idle();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
  endtask
  initial begin
    MEM_Valid = 0; MEM_ExcptIn = 0; MEM_Flush = 0; MEM_Advance = 0; MEM_ALUOut = 0; MEM_OutB = 0;
    MEM_LoadEn = 0; MEM_StoreEn = 0; MEM_Size = 0; MEM_LoadSign = 0;
    bus_idle();
    #2;
    check("rst_req", bus.data_req, 0);
    check("rst_stall", MEM_Stall, 0);
    check("rst_load", MEM_LoadData, 0);
    check("rst_adel", MEM_AdEL, 0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    run_instr(32'h1000, 0, 1, 0, 2'd2, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    run_instr(32'h1003, 0, 1, 0, 2'd0, 1, 0, 0, 0, 0, 32'h80FF0000);
    run_instr(32'h1003, 0, 1, 0, 2'd0, 0, 0, 1, 1, 1, 32'h80FF0000);
    run_instr(32'h2002, 32'h1234ABCD, 0, 1, 2'd1, 0, 0, 3, 0, 0, 0);
    run_instr(32'h1001, 0, 1, 0, 2'd2, 0, 0, 0, 0, 0, 0);
    // Flush while waiting for data, then a new load sits in MEM during the drain.
    set_instr(32'h3000, 0, 1, 0, 2'd2, 0, 0); MEM_Advance = 0; bus.data_addr_ok = 1;
    @(negedge clk); check("fw_req", bus.data_req, 1); next_cycle();
    bus.data_addr_ok = 0; MEM_Flush = 1;
    @(negedge clk); check("fw_wait_stall", MEM_Stall, 1); check("fw_wait_req", bus.data_req, 0); next_cycle();
    set_instr(32'h3004, 0, 1, 0, 2'd2, 0, 0);
    @(negedge clk); check("fw_drain_req", bus.data_req, 0); check("fw_drain_stall", MEM_Stall, 1); next_cycle();
    bus.data_data_ok = 1; bus.data_rdata = 32'h11111111;
    @(negedge clk); check("fw_drain2_req", bus.data_req, 0); check("fw_drain2_stall", MEM_Stall, 1); next_cycle();
    bus_idle();
    run_instr(32'h3004, 0, 1, 0, 2'd2, 0, 0, 0, 0, 0, 32'h22222222);
    // Flush in REQ without addr_ok.
    set_instr(32'h4000, 0, 1, 0, 2'd2, 0, 0); MEM_Advance = 0;
    @(negedge clk); check("fr_req0", bus.data_req, 1); next_cycle();
    MEM_Flush = 1;
    @(negedge clk); check("fr_req1", bus.data_req, 1); check("fr_stall1", MEM_Stall, 1); next_cycle();
    MEM_Flush = 0; MEM_Valid = 0;
    @(negedge clk); check("fr_idle_req", bus.data_req, 0); check("fr_idle_stall", MEM_Stall, 0); next_cycle();
    // Flush in REQ together with addr_ok: transaction is outstanding, so drain it.
    set_instr(32'h4000, 0, 1, 0, 2'd2, 0, 0);
    @(negedge clk); next_cycle();
    MEM_Flush = 1; bus.data_addr_ok = 1;
    @(negedge clk); check("fra_req", bus.data_req, 1); next_cycle();
    MEM_Flush = 0; MEM_Valid = 0; bus.data_addr_ok = 0;
    @(negedge clk); check("fra_drain_stall", MEM_Stall, 1); check("fra_drain_req", bus.data_req, 0); next_cycle();
    bus.data_data_ok = 1;
    @(negedge clk); check("fra_drain2_stall", MEM_Stall, 1); next_cycle();
    bus_idle();
    @(negedge clk); check("fra_idle_stall", MEM_Stall, 0); next_cycle();
    // Reset in the middle of a transaction.
    set_instr(32'h5000, 0, 1, 0, 2'd2, 0, 0); bus.data_addr_ok = 1;
    next_cycle();
    bus.data_addr_ok = 0;
    rst = 1'b1;
    #1;
    check("mrst_req", bus.data_req, 0);
    check("mrst_stall", MEM_Stall, 0);
    check("mrst_load", MEM_LoadData, 0);
    MEM_Valid = 0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk); check("mrst_idle_stall", MEM_Stall, 0); next_cycle();
    for (int i = 0; i < 200; i++) begin
      int k = $urandom % 8;
      run_instr($urandom, $urandom, k < 3, k >= 3 && k < 6, 2'($urandom % 4), 1'($urandom % 2),
                $urandom % 8 == 0, $urandom % 4, $urandom % 4, $urandom % 3, $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
